// File: rtl/scale_row_req.sv
// Horizontal nearest-neighbour row scaler: requests each destination row from the
// line-buffer filler, reads the line RAM at rounded source columns and streams pixels out.
module scale_row_req #(
  parameter logic [10:0] SRC_W     = 11'd640,
  parameter logic [10:0] DST_W     = 11'd1280,
  parameter logic [10:0] DST_H     = 11'd720,
  parameter int unsigned FLOAT_LEN = 11,
  parameter int unsigned FIX_LEN   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FIX_LEN-1:0] x_scale,
  output logic               wr_req,
  output logic [10:0]        dst_row,
  input  logic               tran_done,
  output logic               ram_rd_en,
  output logic [10:0]        ram_rd_addr,
  input  logic [15:0]        ram_rd_data,
  output logic               pix_valid,
  output logic [15:0]        pix_data,
  input  logic               pix_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned ACC_W = FIX_LEN + 11;
  localparam int unsigned INT_W = ACC_W - FLOAT_LEN;

  typedef enum logic [2:0] {IDLE, REQ, READ, DRAIN, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [10:0]      col;
  logic             rd_pend;
  logic [1:0]       cnt, cnt_n;
  logic [15:0]      buf0, buf1, buf0_n, buf1_n;
  logic             pop, issue;
  logic [INT_W:0]   src_raw;
  logic [10:0]      src_col;

  always_comb begin
    src_raw = {1'b0, acc[ACC_W-1:FLOAT_LEN]} + {{INT_W{1'b0}}, acc[FLOAT_LEN-1]};
    if (src_raw > {{(INT_W-10){1'b0}}, SRC_W - 11'd1})
      src_col = SRC_W - 11'd1;
    else
      src_col = src_raw[10:0];
  end

  // The returning RAM word is presented directly when the buffer is empty, giving
  // one-cycle read-to-valid latency; it is only captured if it cannot leave this cycle.
  assign pix_valid  = (cnt != 2'd0) || rd_pend;
  assign pix_data   = (cnt != 2'd0) ? buf0 : (rd_pend ? ram_rd_data : '0);
  assign pop        = pix_valid && pix_ready;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_comb begin
    cnt_n  = cnt;
    buf0_n = buf0;
    buf1_n = buf1;
    if (cnt == 2'd0) begin
      if (rd_pend && !pix_ready) begin
        buf0_n = ram_rd_data;
        cnt_n  = 2'd1;
      end
    end else if (cnt == 2'd1) begin
      if (pop && rd_pend) begin
        buf0_n = ram_rd_data;
      end else if (pop) begin
        cnt_n = 2'd0;
      end else if (rd_pend) begin
        buf1_n = ram_rd_data;
        cnt_n  = 2'd2;
      end
    end else begin
      if (pop) begin
        buf0_n = buf1;
        cnt_n  = 2'd1;
      end
    end
  end

  // Next cycle's in-flight read is the one currently strobed, so buffered plus
  // in-flight (including any new issue) never exceeds two.
  assign issue = (state == READ) && (({1'b0, cnt_n} + {2'b00, ram_rd_en}) < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_req      <= 1'b0;
      dst_row     <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= 11'd1;
      acc         <= '0;
      col         <= '0;
      rd_pend     <= 1'b0;
      cnt         <= '0;
      buf0        <= '0;
      buf1        <= '0;
    end else begin
      cnt       <= cnt_n;
      buf0      <= buf0_n;
      buf1      <= buf1_n;
      rd_pend   <= ram_rd_en;
      ram_rd_en <= issue;
      if (issue) begin
        ram_rd_addr <= src_col + 11'd1;
        acc         <= acc + {{(ACC_W-FIX_LEN){1'b0}}, x_scale};
        col         <= col + 11'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= REQ;
            wr_req  <= 1'b1;
            dst_row <= '0;
            acc     <= '0;
            col     <= '0;
          end
        end
        REQ: begin
          if (tran_done) begin
            state  <= READ;
            wr_req <= 1'b0;
            acc    <= '0;
            col    <= '0;
          end
        end
        READ: begin
          if (issue && (col == DST_W - 11'd1))
            state <= DRAIN;
        end
        DRAIN: begin
          if ((cnt == 2'd0) && !rd_pend && !ram_rd_en) begin
            if (dst_row == DST_H - 11'd1) begin
              state <= DONE;
            end else begin
              dst_row <= dst_row + 11'd1;
              wr_req  <= 1'b1;
              state   <= REQ;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          dst_row <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/scale_row_req.md
SCALE_ROW_REQ -- requirements
Module: scale_row_req

Interface
REQ-001 Parameter SRC_W, default 11'd640, source row width in pixels.
REQ-002 Parameter DST_W, default 11'd1280, destination row width in pixels.
REQ-003 Parameter DST_H, default 11'd720, destination rows per frame.
REQ-004 Parameter FLOAT_LEN, default 11, fractional bits of x_scale.
REQ-005 Parameter FIX_LEN, default 15, total width of x_scale.
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle frame start pulse.
REQ-009 x_scale  input  FIX_LEN  unsigned 4.11 horizontal step (SRC_W/DST_W).
REQ-010 wr_req  output  1  new-row request to the line-buffer filler.
REQ-011 dst_row  output  11  destination row being requested/emitted.
REQ-012 tran_done  input  1  filler reports the requested row is in line RAM.
REQ-013 ram_rd_en  output  1  line-RAM read strobe.
REQ-014 ram_rd_addr  output  11  line-RAM read address, 1-based (pixel 0 at address 1).
REQ-015 ram_rd_data  input  16  line-RAM data, valid exactly 1 cycle after ram_rd_en.
REQ-016 pix_valid  output  1  output pixel valid.
REQ-017 pix_data  output  16  output RGB565 pixel.
REQ-018 pix_ready  input  1  downstream accepts pixel when pix_valid&&pix_ready.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 frame_done  output  1  one-cycle pulse after the last pixel of the frame is accepted.

Function
REQ-021 FSM states: IDLE, REQ, READ, DRAIN, DONE.
REQ-022 IDLE: start=1 -> REQ, dst_row<=0, column state cleared; start ignored in all other states.
REQ-023 REQ: wr_req=1 held continuously, dst_row stable; tran_done=1 -> READ next cycle, wr_req low from that cycle.
REQ-024 tran_done outside REQ is ignored.
REQ-025 READ: per destination column c (0..DST_W-1), accumulator acc (FIX_LEN+11 bits) = c*x_scale, updated incrementally by +x_scale per issued read, cleared at READ entry.
REQ-026 src_col = acc[MSB:FLOAT_LEN] + acc[FLOAT_LEN-1] (round half up), clamped to SRC_W-1; ram_rd_addr = src_col+1.
REQ-027 Read issue allowed only when (buffered pixels + reads in flight) < 2; output is a 2-entry buffer, so no pixel is ever dropped under backpressure.
REQ-028 After read for c=DST_W-1 is issued -> DRAIN; no further ram_rd_en.
REQ-029 Pixel order at output equals column order; pix_data/pix_valid held stable while pix_valid&&!pix_ready.
REQ-030 DRAIN: when buffer empty and no read in flight: dst_row==DST_H-1 -> DONE, else dst_row+1 -> REQ.
REQ-031 DONE: frame_done=1 for one cycle, -> IDLE; dst_row reset to 0.
REQ-032 Minimum latency ram_rd_en -> pix_valid: 1 cycle; with pix_ready constantly 1, one pixel per cycle sustained.
REQ-033 x_scale=0: every pixel reads address 1; overflow of acc beyond SRC_W clamps per REQ-026.

Reset
REQ-034 rst=1 at any edge, including mid-row: state IDLE, wr_req=0, dst_row=0, ram_rd_en=0, ram_rd_addr=1, pix_valid=0, pix_data=0, busy=0, frame_done=0, acc=0, buffer empty, in-flight read discarded.
REQ-035 First start is honoured on the first cycle after rst deasserts.

Verification
REQ-036 start, tran_done returned 5 cycles after wr_req, x_scale=11'd1024 (0.5), pix_ready=1 -> wr_req high exactly until tran_done, addresses 1,2,2,3,3,... , 1280 pixels/row, busy high.
REQ-037 x_scale=15'd2048 (1.0), DST_W=640 -> addresses 1..640 in order, pix_data equals RAM contents.
REQ-038 pix_ready toggled randomly 50% -> no lost/duplicated pixel, pix_data stable while stalled, ram_rd_en never leaves >2 outstanding.
REQ-039 DST_H=3 full frame -> dst_row 0,1,2 requested in sequence, single frame_done pulse after 3rd row's last accept, return to IDLE.
REQ-040 rst asserted mid-row 300 -> next cycle all outputs at reset values; new start restarts from dst_row=0, address 1.
REQ-041 x_scale=15'h7FFF -> addresses clamp at 640; tran_done pulsed in READ ignored; start pulsed while busy ignored.
